// File: rtl/game_round_if.sv
// Handshake bundle between the round sequencer and its environment
// (button/tick/done inputs, mode/enable/timer outputs).
interface game_round_if #(
  parameter int unsigned TW = 6
);
  logic          btn_pulse;
  logic          tick;
  logic [2:0]    done1;
  logic [2:0]    done2;
  logic [1:0]    tog_start;
  logic          enable1;
  logic          enable2;
  logic          time_out;
  logic [TW-1:0] time_left;
  logic [1:0]    wins;

  modport master (
    output btn_pulse, tick, done1, done2,
    input  tog_start, enable1, enable2, time_out, time_left, wins
  );

  modport slave (
    input  btn_pulse, tick, done1, done2,
    output tog_start, enable1, enable2, time_out, time_left, wins
  );
endinterface

// File: rtl/game_round_sequencer.sv
// Round sequencer: IDLE -> game 1 -> game 2 -> IDLE with a per-round tick countdown,
// a held time-out state and a saturating count of games completed in time.
module game_round_sequencer #(
  parameter int unsigned ROUND_TICKS = 30,
  parameter int unsigned TW          = 6
) (
  input  logic         clk,
  input  logic         rst,
  game_round_if.slave  bus
);

  localparam logic [1:0] TOG_IDLE = 2'b00;
  localparam logic [1:0] TOG_G1   = 2'b01;
  localparam logic [1:0] TOG_G2   = 2'b11;
  localparam logic [1:0] WINS_MAX = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G1   = 2'd1,
    S_G2   = 2'd2,
    S_TOUT = 2'd3
  } state_t;

  state_t        state_q;
  logic [1:0]    tog_q;
  logic          en1_q;
  logic          en2_q;
  logic          tout_q;
  logic [TW-1:0] left_q;
  logic [1:0]    wins_q;

  logic [TW-1:0] reload;
  logic          expire;
  logic [1:0]    wins_inc;

  assign reload   = TW'(ROUND_TICKS);
  // Expiry only matters while a game is running; the FSM checks state before using it.
  assign expire   = bus.tick && (left_q == TW'(1));
  assign wins_inc = (wins_q == WINS_MAX) ? WINS_MAX : wins_q + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tog_q   <= TOG_IDLE;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      tout_q  <= 1'b0;
      left_q  <= '0;
      wins_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.btn_pulse) begin
            state_q <= S_G1;
            tog_q   <= TOG_G1;
            en1_q   <= 1'b1;
            left_q  <= reload;
            wins_q  <= '0;
          end
        end

        // Priority within a game: done, then expiry, then button, then plain tick.
        S_G1: begin
          if (bus.done1 != 3'd0) begin
            state_q <= S_G2;
            tog_q   <= TOG_G2;
            en1_q   <= 1'b0;
            en2_q   <= 1'b1;
            left_q  <= reload;
            wins_q  <= wins_inc;
          end else if (expire) begin
            state_q <= S_TOUT;
            en1_q   <= 1'b0;
            tout_q  <= 1'b1;
            left_q  <= '0;
          end else if (bus.btn_pulse) begin
            state_q <= S_G2;
            tog_q   <= TOG_G2;
            en1_q   <= 1'b0;
            en2_q   <= 1'b1;
            left_q  <= reload;
          end else if (bus.tick && (left_q != '0)) begin
            left_q  <= left_q - TW'(1);
          end
        end

        S_G2: begin
          if (bus.done2 != 3'd0) begin
            state_q <= S_IDLE;
            tog_q   <= TOG_IDLE;
            en2_q   <= 1'b0;
            wins_q  <= wins_inc;
          end else if (expire) begin
            state_q <= S_TOUT;
            en2_q   <= 1'b0;
            tout_q  <= 1'b1;
            left_q  <= '0;
          end else if (bus.btn_pulse) begin
            state_q <= S_IDLE;
            tog_q   <= TOG_IDLE;
            en2_q   <= 1'b0;
          end else if (bus.tick && (left_q != '0)) begin
            left_q  <= left_q - TW'(1);
          end
        end

        // tog_start keeps naming the game that ran out until the player acknowledges.
        S_TOUT: begin
          if (bus.btn_pulse) begin
            state_q <= S_IDLE;
            tog_q   <= TOG_IDLE;
            tout_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          tog_q   <= TOG_IDLE;
          en1_q   <= 1'b0;
          en2_q   <= 1'b0;
          tout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tog_start = tog_q;
  assign bus.enable1   = en1_q;
  assign bus.enable2   = en2_q;
  assign bus.time_out  = tout_q;
  assign bus.time_left = left_q;
  assign bus.wins      = wins_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Bench for game_round_sequencer: directed protocol scenarios followed by random traffic,
// every cycle checked against a mode/counter reference model.
module tb_game_round_sequencer;

  localparam int unsigned RT = 4;
  localparam int unsigned TW = 6;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  game_round_if #(.TW(TW)) bus ();

  game_round_sequencer #(.ROUND_TICKS(RT), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: which phase of the round we are in, which game was last running,
  // ticks remaining and games won.
  int m_phase;   // 0 idle, 1 playing game 1, 2 playing game 2, 3 timed out
  int m_game;    // 1 or 2
  int m_left;
  int m_wins;

  function automatic int add_win(int w);
    return (w + 1 > 2) ? 2 : w + 1;
  endfunction

  task automatic model_clk(bit r, bit b, bit t, logic [2:0] d1, logic [2:0] d2);
    bit done;
    if (!r) begin
      m_phase = 0; m_game = 1; m_left = 0; m_wins = 0;
      return;
    end
    done = (m_phase == 1) ? (d1 != 0) : (d2 != 0);
    case (m_phase)
      0: if (b) begin m_phase = 1; m_game = 1; m_left = RT; m_wins = 0; end
      1, 2: begin
        if (done) begin
          m_wins = add_win(m_wins);
          if (m_phase == 1) begin m_phase = 2; m_game = 2; m_left = RT; end
          else m_phase = 0;
        end else if (t && m_left == 1) begin
          m_phase = 3; m_left = 0;
        end else if (b) begin
          if (m_phase == 1) begin m_phase = 2; m_game = 2; m_left = RT; end
          else m_phase = 0;
        end else if (t && m_left > 0) begin
          m_left = m_left - 1;
        end
      end
      3: if (b) m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int tog;
    tog = (m_phase == 0) ? 0 : ((m_game == 1) ? 1 : 3);
    chk("tog_start", 32'(bus.tog_start), 32'(tog));
    chk("enable1",   32'(bus.enable1),   32'(m_phase == 1));
    chk("enable2",   32'(bus.enable2),   32'(m_phase == 2));
    chk("time_out",  32'(bus.time_out),  32'(m_phase == 3));
    chk("time_left", 32'(bus.time_left), 32'(m_left));
    chk("wins",      32'(bus.wins),      32'(m_wins));
  endtask

  // One clock: drive inputs, clock, update model, sample #1 after the edge.
  task automatic cyc(bit b = 0, bit t = 0, logic [2:0] d1 = 3'd0, logic [2:0] d2 = 3'd0, bit r = 1);
    bus.btn_pulse = b;
    bus.tick      = t;
    bus.done1     = d1;
    bus.done2     = d2;
    rst           = r;
    @(posedge clk);
    model_clk(r, b, t, d1, d2);
    #1;
    check_model();
  endtask

  // Directed expectations written straight from the scenario descriptions.
  task automatic expect_out(string tag, int tog, int left, int wins, int tout);
    chk({tag, "_tog"},  32'(bus.tog_start), 32'(tog));
    chk({tag, "_left"}, 32'(bus.time_left), 32'(left));
    chk({tag, "_wins"}, 32'(bus.wins),      32'(wins));
    chk({tag, "_tout"}, 32'(bus.time_out),  32'(tout));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_phase = 0; m_game = 1; m_left = 0; m_wins = 0;
    bus.btn_pulse = 0; bus.tick = 0; bus.done1 = 0; bus.done2 = 0;
    rst = 0;

    // Reset
    cyc(.r(0)); cyc(.r(0));
    expect_out("reset", 0, 0, 0, 0);
    chk("reset_en1", 32'(bus.enable1), 32'd0);
    chk("reset_en2", 32'(bus.enable2), 32'd0);

    // Start, two ticks, game 1 completes
    cyc(.b(1));
    expect_out("start", 1, 4, 0, 0);
    chk("start_en1", 32'(bus.enable1), 32'd1);
    cyc(.t(1)); cyc(.t(1));
    expect_out("g1_tick2", 1, 2, 0, 0);
    cyc(.d1(3'b010));
    expect_out("g1_done", 3, 4, 1, 0);
    chk("g1_done_en2", 32'(bus.enable2), 32'd1);
    cyc(.b(1));
    expect_out("g2_skip", 0, 4, 1, 0);

    // Timeout in game 1, done inputs ignored while timed out
    cyc(.b(1));
    cyc(.t(1)); expect_out("cd3", 1, 3, 0, 0);
    cyc(.t(1)); expect_out("cd2", 1, 2, 0, 0);
    cyc(.t(1)); expect_out("cd1", 1, 1, 0, 0);
    cyc(.t(1)); expect_out("expire", 1, 0, 0, 1);
    chk("expire_en1", 32'(bus.enable1), 32'd0);
    cyc(.t(1), .d1(3'd7), .d2(3'd7));
    expect_out("tout_hold", 1, 0, 0, 1);
    cyc(.b(1));
    expect_out("tout_ack", 0, 0, 0, 0);

    // Done beats expiry in game 2
    cyc(.b(1)); cyc(.d1(3'b001));
    cyc(.t(1)); cyc(.t(1)); cyc(.t(1));
    expect_out("g2_last", 3, 1, 1, 0);
    cyc(.t(1), .d2(3'b001));
    expect_out("done_vs_exp", 0, 1, 2, 0);

    // Button skips, ticks coincident with entry ignored
    cyc(.b(1), .t(1));
    expect_out("skip_g1", 1, 4, 0, 0);
    cyc(.b(1), .t(1));
    expect_out("skip_g2", 3, 4, 0, 0);
    cyc(.b(1));
    expect_out("skip_idle", 0, 4, 0, 0);

    // Reset mid game 2
    cyc(.b(1)); cyc(.d1(3'b101)); cyc(.t(1)); cyc(.t(1));
    expect_out("pre_rst", 3, 2, 1, 0);
    cyc(.r(0));
    expect_out("mid_rst", 0, 0, 0, 0);
    chk("mid_rst_en2", 32'(bus.enable2), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit b, t, r;
      logic [2:0] d1, d2;
      b  = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 2) == 0);
      d1 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      d2 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      r  = ($urandom_range(0, 199) != 0);
      cyc(b, t, d1, d2, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
